spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 187 ++++++++++++++++++
 tb/tb_spi_slave.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) clocked entirely by sys_clk_i.
// SPI pins are oversampled through synchronizer chains; a one-entry TX buffer feeds MISO.
module spi_slave #(
    parameter int DW   = 8,
    parameter int SYNC = 2
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          s_spi_clk_i,
    input  logic          s_spi_cs_i,
    input  logic          s_spi_dat_i,
    output logic          s_spi_dat_o,
    output logic          s_spi_oe_o,
    input  logic [DW-1:0] s_tx_data_i,
    input  logic          s_tx_valid_i,
    output logic          s_tx_ready_o,
    output logic [DW-1:0] m_rx_data_o,
    output logic          m_rx_valid_o,
    output logic          s_busy_o,
    output logic          s_underrun_o,
    output logic          s_abort_o
);
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Synchronizer chains carry no reset so they keep tracking the pins during reset.
    logic [SYNC-1:0] r_sclk_sync;
    logic [SYNC-1:0] r_cs_sync;
    logic [SYNC-1:0] r_mosi_sync;
    logic            r_sclk_hist;
    logic            r_cs_hist;
    logic            r_cs_armed;

    logic [CW-1:0]   r_bit_cnt;
    logic [DW-2:0]   r_rx_shift;
    logic [DW-1:0]   r_rx_data;
    logic            r_rx_valid;
    logic [DW-1:0]   r_tx_shift;
    logic [DW-1:0]   r_tx_buf;
    logic            r_tx_full;
    logic            r_underrun;
    logic            r_abort;

    logic            w_sclk_s;
    logic            w_cs_s;
    logic            w_mosi_s;
    logic            w_sclk_rise;
    logic            w_sclk_fall;
    logic            w_cs_rise;
    logic            w_cs_fall;
    logic            w_start;
    logic            w_stop;
    logic            w_shift_in;
    logic            w_shift_out;
    logic            w_reload;
    logic            w_accept;
    logic [DW-1:0]   w_tx_load;
    logic [DW-1:0]   w_rx_next;

    always_ff @(posedge sys_clk_i) begin
        r_sclk_sync <= {r_sclk_sync[SYNC-2:0], s_spi_clk_i};
        r_cs_sync   <= {r_cs_sync[SYNC-2:0], s_spi_cs_i};
        r_mosi_sync <= {r_mosi_sync[SYNC-2:0], s_spi_dat_i};
    end

    assign w_sclk_s    = r_sclk_sync[SYNC-1];
    assign w_cs_s      = r_cs_sync[SYNC-1];
    assign w_mosi_s    = r_mosi_sync[SYNC-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_hist;
    assign w_cs_rise   = w_cs_s & ~r_cs_hist;
    assign w_cs_fall   = ~w_cs_s & r_cs_hist;

    // A start needs CS to have been seen high since reset, so CS held low through reset is ignored.
    assign w_start     = (r_state == ST_IDLE) & w_cs_fall & r_cs_armed;
    assign w_stop      = (r_state == ST_ACTIVE) & w_cs_rise;
    assign w_shift_in  = (r_state == ST_ACTIVE) & ~w_cs_rise & w_sclk_rise;
    assign w_shift_out = (r_state == ST_ACTIVE) & ~w_cs_rise & w_sclk_fall;
    assign w_reload    = w_start | (w_shift_out & (r_bit_cnt == '0));
    assign w_tx_load   = r_tx_full ? r_tx_buf : '0;
    assign w_rx_next   = {r_rx_shift, w_mosi_s};

    // The buffer is free in a reload cycle too, letting a new word land as the old one leaves.
    assign s_tx_ready_o = ~r_tx_full | w_reload;
    assign w_accept     = s_tx_valid_i & s_tx_ready_o;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start)   w_state_next = ST_ACTIVE;
            ST_ACTIVE: if (w_cs_rise) w_state_next = ST_IDLE;
            default:                  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_sclk_hist <= 1'b0;
            r_cs_hist   <= 1'b1;
            r_cs_armed  <= 1'b0;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_tx_shift  <= '0;
            r_tx_buf    <= '0;
            r_tx_full   <= 1'b0;
            r_underrun  <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_sclk_hist <= w_sclk_s;
            r_cs_hist   <= w_cs_s;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_abort     <= 1'b0;
            if (w_cs_s) begin
                r_cs_armed <= 1'b1;
            end

            if (w_start) begin
                r_bit_cnt  <= '0;
                r_tx_shift <= w_tx_load;
            end

            if (w_stop) begin
                r_bit_cnt  <= '0;
                r_tx_shift <= '0;
                r_abort    <= (r_bit_cnt != '0);
            end

            if (w_shift_in) begin
                r_rx_shift <= w_rx_next[DW-2:0];
                if (r_bit_cnt == LAST_BIT) begin
                    r_bit_cnt  <= '0;
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            if (w_shift_out) begin
                if (r_bit_cnt == '0) begin
                    r_tx_shift <= w_tx_load;
                end else begin
                    r_tx_shift <= r_tx_shift << 1;
                end
            end

            if (w_reload && !r_tx_full) begin
                r_underrun <= 1'b1;
            end

            if (w_accept) begin
                r_tx_buf  <= s_tx_data_i;
                r_tx_full <= 1'b1;
            end else if (w_reload) begin
                r_tx_full <= 1'b0;
            end
        end
    end

    assign s_spi_dat_o  = r_tx_shift[DW-1];
    assign s_spi_oe_o   = (r_state == ST_ACTIVE);
    assign s_busy_o     = (r_state == ST_ACTIVE);
    assign m_rx_data_o  = r_rx_data;
    assign m_rx_valid_o = r_rx_valid;
    assign s_underrun_o = r_underrun;
    assign s_abort_o    = r_abort;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bus-level SPI master, a TX writer and a scoreboard monitor
// checking MISO bits, received words and the underrun/abort pulse counts.
module tb_spi_slave;
    localparam int DW   = 8;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sclk = 1'b0;
    logic          cs = 1'b1;
    logic          mosi = 1'b0;
    logic          miso;
    logic          oe;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic          underrun;
    logic          abort_o;

    always #5 clk = ~clk;

    spi_slave #(.DW(DW), .SYNC(SYNC)) dut (
        .sys_clk_i    (clk),
        .sys_rst_i    (rst),
        .s_spi_clk_i  (sclk),
        .s_spi_cs_i   (cs),
        .s_spi_dat_i  (mosi),
        .s_spi_dat_o  (miso),
        .s_spi_oe_o   (oe),
        .s_tx_data_i  (tx_data),
        .s_tx_valid_i (tx_valid),
        .s_tx_ready_o (ready),
        .m_rx_data_o  (rx_data),
        .m_rx_valid_o (rx_valid),
        .s_busy_o     (busy),
        .s_underrun_o (underrun),
        .s_abort_o    (abort_o)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transfer plan: per word, the MOSI word and the TX word (if any) the slave should send.
    logic [DW-1:0] mosi_w[4];
    logic [DW-1:0] tx_w[4];
    bit            tx_have[4];
    int            bnd_cyc[4];

    logic [DW-1:0] rx_q[$];
    int exp_under = 0;
    int exp_abort = 0;
    int under_seen = 0;
    int abort_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops the expected RX word whenever the DUT raises m_rx_valid_o.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rx_valid === 1'b1) begin
                if (rx_q.size() == 0) begin
                    chk("rx_unexpected_valid", rx_valid, 0);
                end else begin
                    chk("rx_data", rx_data, rx_q.pop_front());
                end
            end
            if (underrun === 1'b1) under_seen++;
            if (abort_o === 1'b1) abort_seen++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tx_write(input logic [DW-1:0] w);
        int n = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tx_write_ready", ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_miso"}, miso, 0);
        chk({tag, "_oe"}, oe, 0);
        chk({tag, "_rx_data"}, rx_data, 0);
        chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_underrun"}, underrun, 0);
        chk({tag, "_abort"}, abort_o, 0);
        chk({tag, "_ready"}, ready, 1);
    endtask

    // Mode-0 master. Ends each transfer by raising CS while SCLK is still high.
    task automatic spi_xfer(input int nw, input int half, input int abort_bits,
                            input int rst_bits, input bit auto_wr);
        logic [DW-1:0] exp_tx;
        bit stop = 1'b0;
        $display("xfer words=%0d half=%0d abort_at=%0d rst_at=%0d mosi0=0x%0h tx0=0x%0h have0=%0d",
                 nw, half, abort_bits, rst_bits, mosi_w[0], tx_w[0], tx_have[0]);
        if (auto_wr && tx_have[0]) tx_write(tx_w[0]);
        cs = 1'b0;
        for (int k = 0; k < nw && !stop; k++) begin
            exp_tx = tx_have[k] ? tx_w[k] : '0;
            if (!tx_have[k]) exp_under++;
            for (int b = 0; b < DW && !stop; b++) begin
                mosi = mosi_w[k][DW-1-b];
                wait_cyc(half);
                chk("miso_bit", miso, exp_tx[DW-1-b]);
                chk("oe_active", oe, 1);
                sclk = 1'b1;
                if (b == DW - 1) rx_q.push_back(mosi_w[k]);
                if (k == 0 && b + 1 == abort_bits) begin
                    wait_cyc(half);
                    cs = 1'b1;
                    exp_abort++;
                    stop = 1'b1;
                end else if (k == 0 && b + 1 == rst_bits) begin
                    wait_cyc(SYNC + 2);
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    check_reset_outputs("midrst");
                    wait_cyc(12);
                    chk("cs_low_after_rst_busy", busy, 0);
                    cs = 1'b1;
                    stop = 1'b1;
                end else begin
                    wait_cyc(half);
                    if (!(k == nw - 1 && b == DW - 1)) begin
                        sclk = 1'b0;
                        if (b == DW - 1) bnd_cyc[k] = cyc;
                        if (auto_wr && b == 2 && k + 1 < nw && tx_have[k + 1]) tx_write(tx_w[k + 1]);
                    end
                end
            end
        end
        cs = 1'b1;
        wait_cyc(half);
        sclk = 1'b0;
        mosi = 1'b0;
        wait_cyc(2 * half + 4);
        chk("idle_oe", oe, 0);
        chk("idle_miso", miso, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic sb_check(input string tag);
        chk({tag, "_underruns"}, under_seen, exp_under);
        chk({tag, "_aborts"}, abort_seen, exp_abort);
        chk({tag, "_rx_pending"}, rx_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) bnd_cyc[i] = 0;
        wait_cyc(6);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_cyc(6);

        // Single word: TX 0xA5 preloaded, master sends 0x3C.
        mosi_w[0] = 8'h3C; tx_w[0] = 8'hA5; tx_have[0] = 1'b1;
        spi_xfer(1, 8, 0, 0, 1'b1);
        chk("basic_rx_data_held", rx_data, 8'h3C);
        sb_check("basic");

        // Two words under one CS, second TX word written during word one.
        mosi_w[0] = DW'($urandom); mosi_w[1] = DW'($urandom);
        tx_w[0] = 8'h11; tx_w[1] = 8'h22; tx_have[0] = 1'b1; tx_have[1] = 1'b1;
        spi_xfer(2, 8, 0, 0, 1'b1);
        sb_check("b2b");

        // No TX word: underrun, MISO zeros, RX still delivered.
        mosi_w[0] = DW'($urandom); tx_have[0] = 1'b0;
        spi_xfer(1, 8, 0, 0, 1'b1);
        sb_check("underrun");

        // CS raised after 5 bits, then a clean transfer.
        mosi_w[0] = DW'($urandom); tx_w[0] = DW'($urandom); tx_have[0] = 1'b1;
        spi_xfer(1, 8, 5, 0, 1'b1);
        sb_check("abort");
        mosi_w[0] = DW'($urandom); tx_w[0] = DW'($urandom); tx_have[0] = 1'b1;
        spi_xfer(1, 8, 0, 0, 1'b1);
        sb_check("after_abort");

        // Reset at bit 3 with CS still low; the DUT must stay idle until a fresh CS fall.
        mosi_w[0] = DW'($urandom); tx_w[0] = DW'($urandom); tx_have[0] = 1'b1;
        spi_xfer(1, 8, 0, 3, 1'b1);
        sb_check("midrst");
        mosi_w[0] = DW'($urandom); tx_w[0] = DW'($urandom); tx_have[0] = 1'b1;
        spi_xfer(1, 8, 0, 0, 1'b1);
        sb_check("after_rst");

        // Valid held while buffer full: accept lands exactly in the word-boundary reload cycle.
        for (int k = 0; k < 3; k++) begin
            mosi_w[k] = DW'($urandom);
            tx_w[k]   = DW'($urandom);
            tx_have[k] = 1'b1;
        end
        tx_write(tx_w[0]);
        bnd_cyc[0] = 0;
        fork
            spi_xfer(3, 8, 0, 0, 1'b0);
            begin
                int n = 0;
                while (busy !== 1'b1 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                wait_cyc(8);
                tx_write(tx_w[1]);
                tx_data  = tx_w[2];
                tx_valid = 1'b1;
                n = 0;
                while (ready !== 1'b1 && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                chk("hold_ready_seen", ready, 1);
                chk("hold_accept_latency", cyc + 1 - bnd_cyc[0], SYNC + 1);
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        sb_check("hold");

        // Randomized transfers against the plan-level model.
        for (int t = 0; t < 8; t++) begin
            int nw;
            int half;
            nw   = int'($urandom_range(1, 3));
            half = int'($urandom_range(5, 10));
            for (int k = 0; k < 4; k++) begin
                mosi_w[k]  = DW'($urandom);
                tx_w[k]    = DW'($urandom);
                tx_have[k] = 1'($urandom_range(0, 1));
            end
            spi_xfer(nw, half, 0, 0, 1'b1);
            sb_check("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
